// File: rtl/decode_queue.sv
// Decode queue: FIFO of raw MIPS instruction words with field decode of the head entry.
// Optional same-cycle bypass when empty is enabled by defining DECODE_QUEUE_BYPASS_EN.
module decode_queue #(
   parameter int unsigned DEPTH = 4,
   parameter int unsigned XLEN  = 32
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         flush,
   input  logic                         in_valid,
   output logic                         in_ready,
   input  logic [31:0]                  in_ins,
   output logic                         out_valid,
   input  logic                         out_ready,
   output logic [5:0]                   op,
   output logic [5:0]                   func,
   output logic [4:0]                   sftamt,
   output logic [4:0]                   rs,
   output logic [4:0]                   rt,
   output logic [4:0]                   rd,
   output logic [XLEN-1:0]              imm_ext,
   output logic [25:0]                  target,
   output logic [2:0]                   cls,
   output logic [$clog2(DEPTH+1)-1:0]   count
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned CW = $clog2(DEPTH+1);

   localparam logic [2:0] CLS_R     = 3'd0;
   localparam logic [2:0] CLS_ALUI  = 3'd1;
   localparam logic [2:0] CLS_LOAD  = 3'd2;
   localparam logic [2:0] CLS_STORE = 3'd3;
   localparam logic [2:0] CLS_BR    = 3'd4;
   localparam logic [2:0] CLS_JUMP  = 3'd5;
   localparam logic [2:0] CLS_OTHER = 3'd7;

   typedef struct packed {
      logic [5:0]      op;
      logic [5:0]      func;
      logic [4:0]      sftamt;
      logic [4:0]      rs;
      logic [4:0]      rt;
      logic [4:0]      rd;
      logic [XLEN-1:0] imm_ext;
      logic [25:0]     target;
      logic [2:0]      cls;
   } dec_t;

   logic [31:0]   mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;

   logic          empty;
   logic          full;
   logic          bypass;
   logic          enq;
   logic          deq;
   logic          wr;
   logic          pop;
   logic [31:0]   head_ins;
   dec_t          dec;

   // Field extraction, immediate extension and class of one instruction word.
   function automatic dec_t decode(input logic [31:0] ins);
      dec_t d;
      d         = '0;
      d.op      = ins[31:26];
      d.rs      = ins[25:21];
      d.rt      = ins[20:16];
      d.rd      = ins[15:11];
      d.sftamt  = ins[10:6];
      d.func    = ins[5:0];
      d.target  = ins[25:0];
      case (ins[31:26])
         6'h0C, 6'h0D, 6'h0E: d.imm_ext = XLEN'(ins[15:0]);
         6'h0F:               d.imm_ext = XLEN'({ins[15:0], 16'h0000});
         default:             d.imm_ext = {{(XLEN-16){ins[15]}}, ins[15:0]};
      endcase
      case (ins[31:26])
         6'h00:                      d.cls = CLS_R;
         6'h08, 6'h09, 6'h0A, 6'h0B,
         6'h0C, 6'h0D, 6'h0E, 6'h0F: d.cls = CLS_ALUI;
         6'h23:                      d.cls = CLS_LOAD;
         6'h2B:                      d.cls = CLS_STORE;
         6'h04, 6'h05:               d.cls = CLS_BR;
         6'h02, 6'h03:               d.cls = CLS_JUMP;
         default:                    d.cls = CLS_OTHER;
      endcase
      return d;
   endfunction

   assign empty = (count == '0);
   assign full  = (count == CW'(DEPTH));

`ifdef DECODE_QUEUE_BYPASS_EN
   assign bypass   = !rst && !flush && empty && in_valid;
   assign head_ins = bypass ? in_ins : mem[rd_ptr];
`else
   assign bypass   = 1'b0;
   assign head_ins = mem[rd_ptr];
`endif

   assign in_ready  = !rst && !flush && !full;
   assign out_valid = !rst && !flush && (!empty || bypass);
   assign enq       = in_valid && in_ready;
   assign deq       = out_valid && out_ready;

   // A bypassed word that is consumed immediately never touches storage.
   assign wr  = enq && !(bypass && out_ready);
   assign pop = deq && !bypass;

   always_comb begin
      dec = '0;
      if (out_valid) dec = decode(head_ins);
   end

   assign op      = dec.op;
   assign func    = dec.func;
   assign sftamt  = dec.sftamt;
   assign rs      = dec.rs;
   assign rt      = dec.rt;
   assign rd      = dec.rd;
   assign imm_ext = dec.imm_ext;
   assign target  = dec.target;
   assign cls     = dec.cls;

   // Pointers and occupancy; reset outranks flush, flush outranks handshakes.
   always_ff @(posedge clk) begin
      if (rst || flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (wr)  wr_ptr <= wr_ptr + AW'(1);
         if (pop) rd_ptr <= rd_ptr + AW'(1);
         count <= count + CW'(wr) - CW'(pop);
      end
   end

   // Storage needs no reset; occupancy alone qualifies its contents.
   always_ff @(posedge clk) begin
      if (!rst && !flush && wr) mem[wr_ptr] <= in_ins;
   end

endmodule

// File: tb/tb_decode_queue.sv
// Self-checking bench for decode_queue: queue-based reference model plus directed literal checks.
module tb_decode_queue;
   localparam int unsigned DEPTH = 4;
   localparam int unsigned XLEN  = 32;

   logic              clk = 1'b0;
   logic              rst, flush, in_valid, in_ready, out_valid, out_ready;
   logic [31:0]       in_ins;
   logic [5:0]        op, func;
   logic [4:0]        sftamt, rs, rt, rd;
   logic [XLEN-1:0]   imm_ext;
   logic [25:0]       target;
   logic [2:0]        cls;
   logic [$clog2(DEPTH+1)-1:0] count;

   int          n_cmp = 0;
   int          n_bad = 0;
   bit          chk_en = 1'b0;
   logic [31:0] mq[$];
   logic [31:0] words [8];

   always #5 clk = ~clk;

   decode_queue #(.DEPTH(DEPTH), .XLEN(XLEN)) dut (
      .clk(clk), .rst(rst), .flush(flush),
      .in_valid(in_valid), .in_ready(in_ready), .in_ins(in_ins),
      .out_valid(out_valid), .out_ready(out_ready),
      .op(op), .func(func), .sftamt(sftamt), .rs(rs), .rt(rt), .rd(rd),
      .imm_ext(imm_ext), .target(target), .cls(cls), .count(count)
   );

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: actual=0x%0h required=0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [31:0] m_imm(input logic [31:0] w);
      logic [15:0] i;
      i = w[15:0];
      if (w[31:26] == 6'h0C || w[31:26] == 6'h0D || w[31:26] == 6'h0E) return {16'h0000, i};
      if (w[31:26] == 6'h0F) return {i, 16'h0000};
      return {{16{i[15]}}, i};
   endfunction

   function automatic logic [2:0] m_cls(input logic [5:0] o);
      if (o == 6'h00) return 3'd0;
      if (o >= 6'h08 && o <= 6'h0F) return 3'd1;
      if (o == 6'h23) return 3'd2;
      if (o == 6'h2B) return 3'd3;
      if (o == 6'h04 || o == 6'h05) return 3'd4;
      if (o == 6'h02 || o == 6'h03) return 3'd5;
      return 3'd7;
   endfunction

   function automatic bit m_byp();
`ifdef DECODE_QUEUE_BYPASS_EN
      return !rst && !flush && (mq.size() == 0) && in_valid;
`else
      return 1'b0;
`endif
   endfunction

   function automatic bit m_ordy();
      return !rst && !flush && (mq.size() < DEPTH);
   endfunction

   function automatic bit m_oval();
      return !rst && !flush && (mq.size() != 0 || m_byp());
   endfunction

   function automatic logic [31:0] m_head();
      if (m_byp()) return in_ins;
      if (mq.size() != 0) return mq[0];
      return 32'h0;
   endfunction

   // Reference model state update at each active edge.
   always @(posedge clk) begin
      bit acc, take;
      acc  = in_valid && m_ordy();
      take = m_oval() && out_ready;
      if (rst || flush) mq.delete();
      else begin
         if (acc)  mq.push_back(in_ins);
         if (take) void'(mq.pop_front());
      end
      chk_en = 1'b1;
   end

   // Every-cycle comparison of all outputs against the model.
   always @(negedge clk) begin
      bit          v;
      logic [31:0] h;
      if (chk_en) begin
         v = m_oval();
         h = v ? m_head() : 32'h0;
         chk("in_ready",  64'(in_ready),  64'(m_ordy()));
         chk("out_valid", 64'(out_valid), 64'(v));
         chk("count",     64'(count),     64'(mq.size()));
         chk("op",        64'(op),        64'(h[31:26]));
         chk("rs",        64'(rs),        64'(h[25:21]));
         chk("rt",        64'(rt),        64'(h[20:16]));
         chk("rd",        64'(rd),        64'(h[15:11]));
         chk("sftamt",    64'(sftamt),    64'(h[10:6]));
         chk("func",      64'(func),      64'(h[5:0]));
         chk("target",    64'(target),    64'(h[25:0]));
         chk("imm_ext",   64'(imm_ext),   v ? 64'(m_imm(h)) : 64'h0);
         chk("cls",       64'(cls),       v ? 64'(m_cls(h[31:26])) : 64'h0);
      end
   end

   task automatic drv(input logic v, input logic [31:0] w, input logic ordy,
                      input logic fl = 1'b0, input logic r = 1'b0);
      in_valid  = v;
      in_ins    = w;
      out_ready = ordy;
      flush     = fl;
      rst       = r;
   endtask

   task automatic nxt();
      @(posedge clk);
      #1;
   endtask

   initial begin
      words[0] = 32'h8C430010; words[1] = 32'h3042FFFF;
      words[2] = 32'h2042FFFF; words[3] = 32'h3C011234;
      words[4] = 32'h00851020; words[5] = 32'hAC22FFF0;
      words[6] = 32'h1000FFFE; words[7] = 32'hFC000000;

      drv(1'b1, 32'h8C430010, 1'b1, 1'b0, 1'b1);
      @(negedge clk);
      chk("rst_in_ready",  64'(in_ready),  64'h0);
      chk("rst_out_valid", 64'(out_valid), 64'h0);
      chk("rst_count",     64'(count),     64'h0);
      chk("rst_cls",       64'(cls),       64'h0);
      nxt();

      // lw after reset
      drv(1'b1, 32'h8C430010, 1'b0); nxt();
      drv(1'b0, 32'h0, 1'b0);
      @(negedge clk);
      chk("lw_valid", 64'(out_valid), 64'h1);
      chk("lw_cls",   64'(cls),       64'h2);
      chk("lw_rs",    64'(rs),        64'h2);
      chk("lw_rt",    64'(rt),        64'h3);
      chk("lw_imm",   64'(imm_ext),   64'h10);
      chk("lw_count", 64'(count),     64'h1);
      nxt();
      drv(1'b0, 32'h0, 1'b1); nxt();
      drv(1'b0, 32'h0, 1'b0);
      @(negedge clk);
      chk("lw_empty_valid", 64'(out_valid), 64'h0);
      chk("lw_empty_op",    64'(op),        64'h0);
      nxt();

      // immediate extension: andi, addi, lui
      drv(1'b1, 32'h3042FFFF, 1'b0); nxt();
      drv(1'b1, 32'h2042FFFF, 1'b0); nxt();
      drv(1'b1, 32'h3C011234, 1'b0); nxt();
      drv(1'b0, 32'h0, 1'b1);
      @(negedge clk); chk("andi_imm", 64'(imm_ext), 64'h0000FFFF); nxt();
      @(negedge clk); chk("addi_imm", 64'(imm_ext), 64'hFFFFFFFF); nxt();
      @(negedge clk); chk("lui_imm",  64'(imm_ext), 64'h12340000);
      chk("lui_cls", 64'(cls), 64'h1); nxt();

      // fill to full with 5 attempts, then drain in order
      for (int i = 0; i < 5; i++) begin
         drv(1'b1, 32'h08000001 + 32'(i), 1'b0);
         if (i == 4) begin
            @(negedge clk);
            chk("full_in_ready", 64'(in_ready), 64'h0);
            chk("full_count",    64'(count),    64'h4);
         end
         nxt();
      end
      drv(1'b1, 32'h08000005, 1'b1);
      @(negedge clk);
      chk("full_deq_in_ready", 64'(in_ready), 64'h0);
      chk("drain_target0",     64'(target),   64'h1);
      nxt();
      for (int i = 1; i < 4; i++) begin
         drv(1'b0, 32'h0, 1'b1);
         @(negedge clk);
         chk("drain_target", 64'(target), 64'(i + 1));
         nxt();
      end
      drv(1'b0, 32'h0, 1'b0);
      @(negedge clk);
      chk("drained_count",  64'(count),     64'h0);
      chk("drained_valid",  64'(out_valid), 64'h0);
      chk("drained_target", 64'(target),    64'h0);
      nxt();

      // streaming across pointer wrap
      drv(1'b1, 32'h20000000, 1'b0); nxt();
      drv(1'b1, 32'h20000001, 1'b0); nxt();
      for (int k = 0; k < 10; k++) begin
         drv(1'b1, 32'h20000002 + 32'(k), 1'b1);
         @(negedge clk);
         chk("stream_count", 64'(count),   64'h2);
         chk("stream_head",  64'(imm_ext), 64'(k));
         nxt();
      end
      drv(1'b0, 32'h0, 1'b1); nxt(); nxt();

      // flush with simultaneous enqueue at count=3
      for (int i = 0; i < 3; i++) begin drv(1'b1, 32'h8C000000 + 32'(i), 1'b0); nxt(); end
      drv(1'b1, 32'hDEADBEEF, 1'b0, 1'b1);
      @(negedge clk);
      chk("flush_in_ready",  64'(in_ready),  64'h0);
      chk("flush_out_valid", 64'(out_valid), 64'h0);
      nxt();
      drv(1'b0, 32'h0, 1'b0);
      @(negedge clk);
      chk("post_flush_count", 64'(count),     64'h0);
      chk("post_flush_valid", 64'(out_valid), 64'h0);
      nxt();

      // reset mid-stream
      drv(1'b1, 32'hAC000001, 1'b0); nxt();
      drv(1'b1, 32'hAC000002, 1'b1); nxt();
      drv(1'b1, 32'hAC000003, 1'b1, 1'b1, 1'b1); nxt();
      drv(1'b0, 32'h0, 1'b0);
      @(negedge clk);
      chk("post_rst_count", 64'(count),     64'h0);
      chk("post_rst_valid", 64'(out_valid), 64'h0);
      nxt();

`ifdef DECODE_QUEUE_BYPASS_EN
      drv(1'b1, 32'h00851020, 1'b1);
      @(negedge clk);
      chk("byp_valid", 64'(out_valid), 64'h1);
      chk("byp_cls",   64'(cls),       64'h0);
      chk("byp_rd",    64'(rd),        64'h2);
      chk("byp_func",  64'(func),      64'h20);
      chk("byp_count", 64'(count),     64'h0);
      nxt();
      drv(1'b0, 32'h0, 1'b0);
      @(negedge clk);
      chk("byp_after_count", 64'(count),     64'h0);
      chk("byp_after_valid", 64'(out_valid), 64'h0);
      nxt();
`else
      drv(1'b1, 32'h00851020, 1'b1);
      @(negedge clk);
      chk("nobyp_valid", 64'(out_valid), 64'h0);
      chk("nobyp_count", 64'(count),     64'h0);
      nxt();
      drv(1'b0, 32'h0, 1'b1);
      @(negedge clk);
      chk("nobyp_next_valid", 64'(out_valid), 64'h1);
      chk("nobyp_next_rd",    64'(rd),        64'h2);
      chk("nobyp_next_func",  64'(func),      64'h20);
      chk("nobyp_next_count", 64'(count),     64'h1);
      nxt();
`endif

      // mixed traffic against the model
      for (int c = 0; c < 80; c++) begin
         drv(1'($urandom_range(0, 1)), words[$urandom_range(0, 7)],
             1'($urandom_range(0, 1)), 1'($urandom_range(0, 15) == 0));
         nxt();
      end
      drv(1'b0, 32'h0, 1'b1);
      repeat (6) nxt();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
